// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_responder_pkg : shared CPU data-memory types and defaults      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package dmem_responder_pkg;

  localparam int DMEM_DEPTH   = 128;
  localparam int DMEM_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_array : word memory, one sync write port, one registered read |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Read register holds zero except in the cycle after a read strobe.
  always_ff @(posedge clk) begin
    if (rst || !rd_en) rd_data <= '0;
    else               rd_data <= mem[rd_idx];
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dmem_responder : fixed-latency data-memory responder for CPU MEM    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
  localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);
  localparam bit          DIRECT     = (LATENCY == 1);

  dmem_state_t   state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          accept, enter_resp;
  logic [31:0]   addr_q, wdata_q;
  logic          we_q;
  logic [31:0]   cur_addr, cur_wdata;
  logic          cur_we;
  logic          addr_err;
  logic [AW-1:0] idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    busy_o     = 1'b0;
    case (state)
      IDLE, RESP: begin
        busy_o = req_i;
        if (req_i) begin
          accept = 1'b1;
          if (DIRECT) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
            cnt_nxt    = '0;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        busy_o = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      addr_q  <= addr_i;
      we_q    <= we_i;
      wdata_q <= wdata_i;
    end
  end

  // With single-cycle latency the request completes on its own accept edge,
  // so the live inputs are used instead of the latched copy.
  assign cur_addr  = DIRECT ? addr_i  : addr_q;
  assign cur_we    = DIRECT ? we_i    : we_q;
  assign cur_wdata = DIRECT ? wdata_i : wdata_q;
  assign addr_err  = (cur_addr[1:0] != 2'b00) || (cur_addr >= ADDR_LIMIT);
  assign idx       = cur_addr[AW+1:2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      ack_o <= enter_resp;
      err_o <= enter_resp && addr_err;
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (enter_resp && !rst_i && cur_we && !addr_err),
    .wr_idx  (idx),
    .wr_data (cur_wdata),
    .rd_en   (enter_resp && !cur_we && !addr_err),
    .rd_idx  (idx),
    .rd_data (rdata_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_dmem_responder : directed bench, LATENCY=2 and LATENCY=1 copies  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata;
  logic        busy2, ack2, err2;
  logic [31:0] rdata2;
  logic        busy1, ack1, err1;
  logic [31:0] rdata1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(128), .LATENCY(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .busy_o(busy2), .ack_o(ack2), .rdata_o(rdata2), .err_o(err2)
  );

  dmem_responder #(.DEPTH(128), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .busy_o(busy1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One transaction on the LATENCY=2 copy; returns at #1 after the ack edge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    req = 1'b1; we = w; addr = a; wdata = d;
    #1;
    check("busy_present", busy2, 1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    check("busy_accept", busy2, 1);
    lat = 99; rd = '0; er = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (ack2) begin
        lat = i; rd = rdata2; er = err2;
        check("busy_resp_idle", busy2, 0);
        break;
      end
      check("busy_wait", busy2, 1);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        seen;
  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_data [4];

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    tick(); tick();
    check("rst_ack", ack2, 0);
    check("rst_err", err2, 0);
    check("rst_rdata", rdata2, 0);
    check("rst_busy", busy2, 0);
    rst = 1'b0;
    tick();

    xfer(1'b1, 32'h0, 32'h1111_1111, rd, er, lat);
    check("st0_lat", lat, 2);
    check("st0_err", er, 0);

    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    check("st10_lat", lat, 2);
    check("st10_rdata", rd, 0);
    check("st10_err", er, 0);
    xfer(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("ld10_lat", lat, 2);
    check("ld10_rdata", rd, 32'hDEAD_BEEF);
    check("ld10_err", er, 0);
    tick();
    check("ack_pulse", ack2, 0);
    check("rdata_after", rdata2, 0);

    xfer(1'b1, 32'h13, 32'h1234_5678, rd, er, lat);
    check("mis_lat", lat, 2);
    check("mis_err", er, 1);
    check("mis_rdata", rd, 0);
    xfer(1'b0, 32'h10, 32'h0, rd, er, lat);
    check("mis_keep", rd, 32'hDEAD_BEEF);

    xfer(1'b0, 32'h200, 32'h0, rd, er, lat);
    check("oor_ld_err", er, 1);
    check("oor_ld_rdata", rd, 0);
    xfer(1'b1, 32'h200, 32'hFFFF_FFFF, rd, er, lat);
    check("oor_st_err", er, 1);
    xfer(1'b0, 32'h0, 32'h0, rd, er, lat);
    check("oor_no_alias", rd, 32'h1111_1111);
    check("ld0_err", er, 0);
    xfer(1'b1, 32'h1FC, 32'h0BAD_F00D, rd, er, lat);
    check("top_st_err", er, 0);
    xfer(1'b0, 32'h1FC, 32'h0, rd, er, lat);
    check("top_ld_err", er, 0);
    check("top_ld_rdata", rd, 32'h0BAD_F00D);

    xfer(1'b1, 32'h20, 32'h1212_1212, rd, er, lat);
    tick();

    // Abort: reset lands one edge after the store is accepted.
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAA_5555;
    tick();
    req = 1'b0; we = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy2, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | ack2;
    end
    check("abort_no_ack", seen, 0);

    // A request presented on a reset edge is ignored.
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h5555_5555; rst = 1'b1;
    tick();
    req = 1'b0; we = 1'b0; rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | ack2;
    end
    check("rst_edge_no_ack", seen, 0);

    xfer(1'b0, 32'h20, 32'h0, rd, er, lat);
    check("abort_old_val", rd, 32'h1212_1212);
    tick();

    // Four held loads against the LATENCY=1 copy.
    b2b_addr[0] = 32'h10;  b2b_data[0] = 32'hDEAD_BEEF;
    b2b_addr[1] = 32'h0;   b2b_data[1] = 32'h1111_1111;
    b2b_addr[2] = 32'h1FC; b2b_data[2] = 32'h0BAD_F00D;
    b2b_addr[3] = 32'h10;  b2b_data[3] = 32'hDEAD_BEEF;
    req = 1'b1; we = 1'b0; addr = b2b_addr[0];
    #1;
    check("l1_busy", busy1, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("b2b_ack%0d", i), ack1, 1);
      check($sformatf("b2b_data%0d", i), rdata1, b2b_data[i]);
      check($sformatf("b2b_err%0d", i), err1, 0);
      if (i < 3) addr = b2b_addr[i+1];
      else       req = 1'b0;
    end
    tick();
    check("b2b_end_ack", ack1, 0);
    check("b2b_end_rdata", rdata1, 0);
    for (int i = 0; i < 6; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
